// File: rtl/pixel_scheduler.sv
// Raster-order pixel dispatcher for a pool of depth engines with in-order result reassembly.
// Optional frame performance counters are enabled by defining SCHED_PERF_CNT_EN.
module pixel_scheduler #(
  parameter int unsigned N_ENG       = 4,
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480
) (
  input  logic                         sysclk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic [9:0]                   max_iter,
  input  logic [WORD_LENGTH-1:0]       re_start,
  input  logic [WORD_LENGTH-1:0]       im_start,
  input  logic [WORD_LENGTH-1:0]       step,
  output logic [N_ENG-1:0]             eng_start,
  output logic [N_ENG*WORD_LENGTH-1:0] eng_re_c,
  output logic [N_ENG*WORD_LENGTH-1:0] eng_im_c,
  output logic [9:0]                   eng_max_iter,
  input  logic [N_ENG-1:0]             eng_done,
  input  logic [N_ENG*10-1:0]          eng_depth,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [9:0]                   pix_depth,
  output logic                         pix_last,
  output logic                         busy,
  output logic                         frame_done,
  output logic [31:0]                  perf_cycles,
  output logic [31:0]                  perf_stalls
);

  localparam int unsigned PtrW  = (N_ENG > 1) ? $clog2(N_ENG) : 1;
  localparam int unsigned XW    = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned YW    = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int unsigned Total = H_RES * V_RES;
  localparam int unsigned CntW  = (Total > 1) ? $clog2(Total) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                         state_q, state_d;
  logic [WORD_LENGTH-1:0]         re_start_q, re_start_d, step_q, step_d;
  logic [WORD_LENGTH-1:0]         re_q, re_d, im_q, im_d;
  logic [9:0]                     max_iter_q, max_iter_d;
  logic [XW-1:0]                  x_q, x_d;
  logic [YW-1:0]                  y_q, y_d;
  logic [PtrW-1:0]                d_ptr_q, d_ptr_d, c_ptr_q, c_ptr_d;
  logic [CntW-1:0]                out_cnt_q, out_cnt_d;
  logic [N_ENG-1:0]               inflight_q, inflight_d;
  logic [N_ENG-1:0]               slot_valid_q, slot_valid_d;
  logic [9:0]                     slot_depth_q [N_ENG];
  logic [9:0]                     slot_depth_d [N_ENG];
  logic [N_ENG-1:0]               eng_start_q, eng_start_d;
  logic [N_ENG*WORD_LENGTH-1:0]   eng_re_c_q, eng_re_c_d, eng_im_c_q, eng_im_c_d;

  logic                   start_frame, dispatch, xfer, last_disp;
  logic [PtrW-1:0]        d_idx;
  logic [XW-1:0]          cur_x;
  logic [YW-1:0]          cur_y;
  logic [WORD_LENGTH-1:0] cur_re, cur_im, cur_step, cur_re0;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(N_ENG - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign busy         = (state_q != StIdle);
  assign pix_valid    = slot_valid_q[c_ptr_q];
  assign pix_depth    = slot_depth_q[c_ptr_q];
  assign pix_last     = pix_valid && (out_cnt_q == CntW'(Total - 1));
  assign xfer         = pix_valid && pix_ready;
  assign frame_done   = xfer && pix_last && (state_q == StDrain);
  assign eng_start    = eng_start_q;
  assign eng_re_c     = eng_re_c_q;
  assign eng_im_c     = eng_im_c_q;
  assign eng_max_iter = max_iter_q;

  always_comb begin
    state_d      = state_q;
    re_start_d   = re_start_q;
    step_d       = step_q;
    re_d         = re_q;
    im_d         = im_q;
    max_iter_d   = max_iter_q;
    x_d          = x_q;
    y_d          = y_q;
    d_ptr_d      = d_ptr_q;
    c_ptr_d      = c_ptr_q;
    out_cnt_d    = out_cnt_q;
    inflight_d   = inflight_q;
    slot_valid_d = slot_valid_q;
    slot_depth_d = slot_depth_q;
    eng_start_d  = '0;
    eng_re_c_d   = eng_re_c_q;
    eng_im_c_d   = eng_im_c_q;

    // Pixel 0 is dispatched straight from the inputs so the first start follows frame_start.
    start_frame = (state_q == StIdle) && frame_start;
    d_idx       = start_frame ? '0 : d_ptr_q;
    cur_x       = start_frame ? '0 : x_q;
    cur_y       = start_frame ? '0 : y_q;
    cur_re      = start_frame ? re_start : re_q;
    cur_im      = start_frame ? im_start : im_q;
    cur_step    = start_frame ? step : step_q;
    cur_re0     = start_frame ? re_start : re_start_q;
    dispatch    = start_frame ||
                  ((state_q == StRun) && !inflight_q[d_ptr_q] && !slot_valid_q[d_ptr_q]);
    last_disp   = (cur_x == XW'(H_RES - 1)) && (cur_y == YW'(V_RES - 1));

    if (start_frame) begin
      state_d    = StRun;
      re_start_d = re_start;
      step_d     = step;
      max_iter_d = max_iter;
      c_ptr_d    = '0;
      out_cnt_d  = '0;
    end

    if (dispatch) begin
      eng_start_d = N_ENG'(1) << d_idx;
      eng_re_c_d[int'(d_idx)*WORD_LENGTH +: WORD_LENGTH] = cur_re;
      eng_im_c_d[int'(d_idx)*WORD_LENGTH +: WORD_LENGTH] = cur_im;
      inflight_d[d_idx] = 1'b1;
      d_ptr_d = ptr_inc(d_idx);
      if (cur_x == XW'(H_RES - 1)) begin
        x_d  = '0;
        y_d  = cur_y + YW'(1);
        re_d = cur_re0;
        im_d = cur_im - cur_step;
      end else begin
        x_d  = cur_x + XW'(1);
        y_d  = cur_y;
        re_d = cur_re + cur_step;
        im_d = cur_im;
      end
      if (last_disp) begin
        state_d = StDrain;
        x_d     = '0;
        y_d     = '0;
      end
    end

    // Results from engines not in flight (e.g. stale after reset) are dropped.
    for (int i = 0; i < int'(N_ENG); i++) begin
      if (eng_done[i] && inflight_q[i]) begin
        inflight_d[i]   = 1'b0;
        slot_valid_d[i] = 1'b1;
        slot_depth_d[i] = eng_depth[i*10 +: 10];
      end
    end

    if (xfer) begin
      slot_valid_d[c_ptr_q] = 1'b0;
      c_ptr_d   = ptr_inc(c_ptr_q);
      out_cnt_d = out_cnt_q + CntW'(1);
      if (frame_done) state_d = StIdle;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q      <= StIdle;
      re_start_q   <= '0;
      step_q       <= '0;
      re_q         <= '0;
      im_q         <= '0;
      max_iter_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      d_ptr_q      <= '0;
      c_ptr_q      <= '0;
      out_cnt_q    <= '0;
      inflight_q   <= '0;
      slot_valid_q <= '0;
      for (int i = 0; i < int'(N_ENG); i++) slot_depth_q[i] <= '0;
      eng_start_q  <= '0;
      eng_re_c_q   <= '0;
      eng_im_c_q   <= '0;
    end else begin
      state_q      <= state_d;
      re_start_q   <= re_start_d;
      step_q       <= step_d;
      re_q         <= re_d;
      im_q         <= im_d;
      max_iter_q   <= max_iter_d;
      x_q          <= x_d;
      y_q          <= y_d;
      d_ptr_q      <= d_ptr_d;
      c_ptr_q      <= c_ptr_d;
      out_cnt_q    <= out_cnt_d;
      inflight_q   <= inflight_d;
      slot_valid_q <= slot_valid_d;
      slot_depth_q <= slot_depth_d;
      eng_start_q  <= eng_start_d;
      eng_re_c_q   <= eng_re_c_d;
      eng_im_c_q   <= eng_im_c_d;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_cycles_q, perf_stalls_q;

  always_ff @(posedge sysclk) begin
    if (reset || start_frame) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (busy) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (pix_valid && !pix_ready) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler: 4x2 frame, 4 model engines with programmable latency.
module tb_pixel_scheduler;
  localparam int N = 4;
  localparam int W = 32;
  localparam int H = 4;
  localparam int V = 2;

  logic           sysclk = 1'b0;
  logic           reset = 1'b1;
  logic           frame_start = 1'b0;
  logic           pix_ready = 1'b1;
  logic [9:0]     max_iter = '0;
  logic [W-1:0]   re_start = '0, im_start = '0, step = '0;
  logic [N-1:0]   eng_start, eng_done;
  logic [N-1:0]   mdone = '0, inj_done = '0;
  logic [N*W-1:0] eng_re_c, eng_im_c;
  logic [9:0]     eng_max_iter, pix_depth;
  logic [N*10-1:0] eng_depth;
  logic           pix_valid, pix_last, busy, frame_done;
  logic [31:0]    perf_cycles, perf_stalls;

  int tests = 0;
  int fails = 0;

  int         lat  [N];
  int         cnt  [N];
  bit         pend [N];
  logic [9:0] mdep [N] = '{default: '0};

  pixel_scheduler #(.N_ENG(N), .WORD_LENGTH(W), .H_RES(H), .V_RES(V)) dut (
    .sysclk(sysclk), .reset(reset), .frame_start(frame_start), .max_iter(max_iter),
    .re_start(re_start), .im_start(im_start), .step(step), .eng_start(eng_start),
    .eng_re_c(eng_re_c), .eng_im_c(eng_im_c), .eng_max_iter(eng_max_iter),
    .eng_done(eng_done), .eng_depth(eng_depth), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_depth(pix_depth), .pix_last(pix_last), .busy(busy), .frame_done(frame_done),
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
  );

  always #5 sysclk = ~sysclk;

  assign eng_done = mdone | inj_done;
  for (genvar g = 0; g < N; g++) begin : g_dep
    assign eng_depth[g*10 +: 10] = mdep[g];
  end

  // Engines report the raster index of the coordinate they were given (step = 1.0 in Q4.28).
  function automatic logic [9:0] depth_of(input logic [W-1:0] re, input logic [W-1:0] im);
    int x, y;
    x = int'($signed(re) >>> 28);
    y = -int'($signed(im) >>> 28);
    return 10'(y * H + x);
  endfunction

  always @(posedge sysclk) begin
    for (int i = 0; i < N; i++) begin
      mdone[i] <= 1'b0;
      if (pend[i]) begin
        if (cnt[i] <= 1) begin
          mdone[i] <= 1'b1;
          pend[i]  <= 1'b0;
        end else begin
          cnt[i] <= cnt[i] - 1;
        end
      end
      if (eng_start[i]) begin
        pend[i] <= 1'b1;
        cnt[i]  <= lat[i];
        mdep[i] <= depth_of(eng_re_c[i*W +: W], eng_im_c[i*W +: W]);
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  task automatic run_frame(input string nm, input int stall_start, input int stall_len,
                           input int glitch_cyc, input logic [9:0] exp_mi);
    int out_k, disp_k, fd_cnt, busy_cnt, stall_rem, el;
    bit done;
    logic [9:0] held;
    logic [3:0] one_hot;
    out_k = 0; disp_k = 0; fd_cnt = 0; busy_cnt = 0; stall_rem = stall_len; done = 0;
    held = '0;
    max_iter    = exp_mi;
    pix_ready   = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    max_iter    = ~exp_mi;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) tick();
      frame_start = (cyc == glitch_cyc);
      if (stall_rem > 0 && cyc >= stall_start && pix_valid === 1'b1) begin
        pix_ready = 1'b0;
        stall_rem--;
      end else begin
        pix_ready = 1'b1;
      end
      #1;
      if (cyc == 0) begin
        check($sformatf("%s_first_start", nm), eng_start, 4'b0001);
        check($sformatf("%s_busy_run", nm), busy, 1'b1);
      end
      if (busy === 1'b1) busy_cnt++;
      if (eng_start !== '0) begin
        one_hot = 4'(1 << (disp_k % N));
        check($sformatf("%s_disp%0d", nm, disp_k), eng_start, one_hot);
        if (disp_k == 5) begin
          check($sformatf("%s_p5_re", nm), eng_re_c[63:32], 32'h1000_0000);
          check($sformatf("%s_p5_im", nm), eng_im_c[63:32], 32'hF000_0000);
        end
        disp_k++;
      end
      if (pix_ready === 1'b0) begin
        el = stall_len - stall_rem;
        if (el == 1) begin
          held = pix_depth;
        end else begin
          check($sformatf("%s_stall_depth", nm), pix_depth, held);
          check($sformatf("%s_stall_valid", nm), pix_valid, 1'b1);
        end
        if (el > 15) check($sformatf("%s_stall_nostart", nm), eng_start, 4'b0000);
      end
      if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
        check($sformatf("%s_depth%0d", nm, out_k), pix_depth, 10'(out_k));
        check($sformatf("%s_last%0d", nm, out_k), pix_last, (out_k == H * V - 1));
        out_k++;
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        done = 1;
        break;
      end
    end
    frame_start = 1'b0;
    pix_ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (frame_done === 1'b1) fd_cnt++;
    end
    check($sformatf("%s_completed", nm), done, 1'b1);
    check($sformatf("%s_out_count", nm), out_k, H * V);
    check($sformatf("%s_disp_count", nm), disp_k, H * V);
    check($sformatf("%s_frame_done_count", nm), fd_cnt, 1);
    check($sformatf("%s_busy_idle", nm), busy, 1'b0);
    check($sformatf("%s_max_iter_latched", nm), eng_max_iter, exp_mi);
`ifdef SCHED_PERF_CNT_EN
    check($sformatf("%s_perf_stalls", nm), perf_stalls, stall_len);
    check($sformatf("%s_perf_cycles", nm), perf_cycles, busy_cnt);
`else
    check($sformatf("%s_perf_stalls", nm), perf_stalls, 0);
    check($sformatf("%s_perf_cycles", nm), perf_cycles, 0);
`endif
  endtask

  initial begin
    int vseen, fdc;
    set_lat(2, 2, 2, 2);
    re_start = 32'h0;
    im_start = 32'h0;
    step     = 32'h1000_0000;
    max_iter = 10'd100;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_re_c", eng_re_c, 0);
    check("rst_eng_im_c", eng_im_c, 0);
    check("rst_eng_max_iter", eng_max_iter, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_depth", pix_depth, 0);
    check("rst_pix_last", pix_last, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_perf_cycles", perf_cycles, 0);
    check("rst_perf_stalls", perf_stalls, 0);
    reset = 1'b0;
    tick();

    run_frame("basic", 1000, 0, -1, 10'd100);

    set_lat(9, 3, 6, 1);
    run_frame("lat9361", 1000, 0, -1, 10'd55);

    set_lat(2, 2, 2, 2);
    run_frame("stall50", 3, 50, -1, 10'd100);

    run_frame("glitch", 1000, 0, 2, 10'd300);

    // Reset in cycle 10 of a frame; stale results must not resurface.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_eng_start", eng_start, 0);
    check("midrst_pix_valid", pix_valid, 0);
    check("midrst_eng_re_c", eng_re_c, 0);
    tick();
    reset = 1'b0;
    vseen = 0;
    fdc   = 0;
    for (int i = 0; i < 15; i++) begin
      inj_done = (i == 12) ? 4'hF : 4'h0;
      tick();
      if (pix_valid === 1'b1) vseen++;
      if (frame_done === 1'b1) fdc++;
    end
    inj_done = 4'h0;
    tick();
    check("midrst_stale_valid", vseen, 0);
    check("midrst_no_frame_done", fdc, 0);
    check("midrst_idle", busy, 0);
    run_frame("post_rst", 1000, 0, -1, 10'd100);

    run_frame("stall7", 2, 7, -1, 10'd100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
